// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo one edge; md_out combinational.
// Backpressure: busy=1 while an op is in flight; start and mthi/mtlo are dropped while busy.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  md_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  logic [CW-1:0] cnt;
  logic          op_div;
  logic          op_sgn;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic          is_md;
  logic          is_div_req;
  logic [63:0]   prod;
  logic [31:0]   dnd;
  logic [31:0]   dvs;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic          div_zero;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign is_md      = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign is_div_req = (md_op == OP_DIV)  || (md_op == OP_DIVU);

  // Result from latched operands: signed divide works on magnitudes then fixes
  // signs, so 0x80000000 / -1 naturally yields 0x80000000 with remainder 0.
  always_comb begin
    prod     = '0;
    dnd      = a_q;
    dvs      = b_q;
    q_mag    = '0;
    r_mag    = '0;
    res_hi   = '0;
    res_lo   = '0;
    div_zero = (b_q == 32'd0);
    if (op_sgn) begin
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      if (a_q[31]) dnd = ~a_q + 32'd1;
      if (b_q[31]) dvs = ~b_q + 32'd1;
    end else begin
      prod = {32'd0, a_q} * {32'd0, b_q};
    end
    if (!div_zero) begin
      q_mag = dnd / dvs;
      r_mag = dnd % dvs;
    end
    if (op_div) begin
      res_lo = (op_sgn && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
      res_hi = (op_sgn && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // Control and HI/LO state: busy+cnt form the IDLE/RUN state, reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      op_div <= 1'b0;
      op_sgn <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (!(op_div && div_zero)) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end else if (start && is_md) begin
      busy   <= 1'b1;
      a_q    <= a;
      b_q    <= b;
      op_div <= is_div_req;
      op_sgn <= (md_op == OP_MULT) || (md_op == OP_DIV);
      cnt    <= is_div_req ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (!start && (md_op == OP_MTHI)) begin
      hi <= a;
    end else if (!start && (md_op == OP_MTLO)) begin
      lo <= a;
    end
  end

  // Read port for mfhi/mflo from the committed registers only.
  always_comb begin
    md_out = '0;
    if (md_op == OP_MFHI)      md_out = hi;
    else if (md_op == OP_MFLO) md_out = lo;
  end

endmodule
